// File: rtl/fb_pkg.sv
// fb_pkg: filter-bank dimensions and scheduler state type shared across the filter bank
package fb_pkg;
  localparam int NUM_CH = 16;
  localparam int DATA_W = 39;
  localparam int CH_W = $clog2(NUM_CH);
  typedef enum logic {IDLE, STREAM} state_t;
endpackage

// File: rtl/fb_out_scheduler_if.sv
// fb_out_scheduler_if: per-channel output stream of the filter-bank scheduler
interface fb_out_scheduler_if #(
  parameter int DATA_W = fb_pkg::DATA_W,
  parameter int CH_W = fb_pkg::CH_W
);
  logic out_valid;
  logic out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CH_W-1:0] out_ch;
  logic out_sof;
  logic out_eof;
  modport master(output out_valid, out_data, out_ch, out_sof, out_eof, input out_ready);
  modport slave(input out_valid, out_data, out_ch, out_sof, out_eof, output out_ready);
endinterface

// File: rtl/fb_next_ch.sv
// fb_next_ch: lowest enabled channel index at or above pos, with a none-left flag
module fb_next_ch #(
  parameter int NUM_CH = fb_pkg::NUM_CH,
  parameter int CH_W = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W:0]     pos,
  output logic [CH_W-1:0]   idx,
  output logic              none
);
  // scan downward so the lowest qualifying index is the last one written
  always_comb begin
    idx = '0;
    none = 1'b1;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (mask[i] && i >= int'(pos)) begin
        idx = CH_W'(i);
        none = 1'b0;
      end
  end
endmodule

// File: rtl/fb_out_scheduler.sv
// fb_out_scheduler: snapshots all filter-bank channels on a strobe and streams them out one per transfer; FB_SCHED_CH_MASK_EN adds a per-frame channel mask
module fb_out_scheduler #(
  parameter int NUM_CH = fb_pkg::NUM_CH,
  parameter int DATA_W = fb_pkg::DATA_W
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     sample_strobe,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
`ifdef FB_SCHED_CH_MASK_EN
  input  logic [NUM_CH-1:0]        ch_mask,
`endif
  fb_out_scheduler_if.master       out,
  output logic                     busy,
  output logic                     overrun,
  input  logic                     overrun_clr,
  output logic [15:0]              frame_cnt
);
  import fb_pkg::*;
  localparam int CH_W = $clog2(NUM_CH);
  state_t state, state_n;
  logic pend, sof_q, xfer, cap, ovr_set, last, none0;
  logic [DATA_W-1:0] snap [NUM_CH];
  logic [NUM_CH-1:0] mask_q, mask_in;
  logic [CH_W-1:0] cur, nxt, first;
  logic [CH_W:0] pos_n;
`ifdef FB_SCHED_CH_MASK_EN
  assign mask_in = ch_mask;
`else
  assign mask_in = '1;
`endif
  assign pos_n = {1'b0, cur} + (CH_W+1)'(1);
  fb_next_ch #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_next (.mask(mask_q), .pos(pos_n), .idx(nxt), .none(last));
  fb_next_ch #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_first (.mask(mask_in), .pos('0), .idx(first), .none(none0));
  // next state and stream outputs; an eof transfer with a coincident strobe parks one cycle in IDLE via pend
  always_comb begin
    out.out_valid = state == STREAM;
    out.out_data = snap[cur];
    out.out_ch = cur;
    out.out_sof = out.out_valid && sof_q;
    out.out_eof = out.out_valid && last;
    busy = state == STREAM;
    xfer = out.out_valid && out.out_ready;
    cap = sample_strobe && !none0 && (state == IDLE || (xfer && last));
    ovr_set = sample_strobe && !none0 && state == STREAM && !(xfer && last);
    state_n = state == IDLE ? ((cap || pend) ? STREAM : IDLE) : ((xfer && last) ? IDLE : STREAM);
  end
  // state register
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  // snapshot capture, channel walk, overrun flag and frame counter
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      pend <= 1'b0;
      sof_q <= 1'b0;
      overrun <= 1'b0;
      frame_cnt <= '0;
      mask_q <= '0;
      cur <= '0;
      for (int i = 0; i < NUM_CH; i++) snap[i] <= '0;
    end else begin
      pend <= cap && state == STREAM;
      overrun <= ovr_set || (overrun && !overrun_clr);
      if (cap) begin
        for (int i = 0; i < NUM_CH; i++) snap[i] <= ch_data[i*DATA_W +: DATA_W];
        mask_q <= mask_in;
        cur <= first;
        sof_q <= 1'b1;
        frame_cnt <= frame_cnt + 16'd1;
      end else if (xfer) begin
        sof_q <= 1'b0;
        if (!last) cur <= nxt;
      end
    end
endmodule

// File: tb/tb_fb_out_scheduler.sv
// tb_fb_out_scheduler: randomized and directed stimulus checked against a frame-queue reference model; define FB_SCHED_CH_MASK_EN to exercise masking
module tb_fb_out_scheduler;
  import fb_pkg::*;
  typedef struct {int ch; logic [DATA_W-1:0] d; logic sof;} item_t;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic sample_strobe = 1'b0;
  logic overrun_clr = 1'b0;
  logic [NUM_CH*DATA_W-1:0] ch_data = '0;
  logic [NUM_CH-1:0] ch_mask = '1;
  logic busy, overrun;
  logic [15:0] frame_cnt;
  int errs = 0;
  int checks = 0;
  item_t q[$];
  logic m_gap = 1'b0;
  logic m_ovr = 1'b0;
  logic [15:0] m_fcnt = '0;
  fb_out_scheduler_if bus();
  fb_out_scheduler dut (
    .clock(clock),
    .reset_n(reset_n),
    .sample_strobe(sample_strobe),
    .ch_data(ch_data),
`ifdef FB_SCHED_CH_MASK_EN
    .ch_mask(ch_mask),
`endif
    .out(bus),
    .busy(busy),
    .overrun(overrun),
    .overrun_clr(overrun_clr),
    .frame_cnt(frame_cnt)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic fill(input bit inc);
    for (int k = 0; k < NUM_CH; k++)
      ch_data[k*DATA_W +: DATA_W] = inc ? DATA_W'(k + 1) : DATA_W'({$urandom(), $urandom()});
  endtask
  task automatic step(input logic s, input logic r, input logic c);
    logic ev, lst, cap;
    sample_strobe = s;
    bus.out_ready = r;
    overrun_clr = c;
    ev = q.size() > 0 && !m_gap;
    chk("valid", bus.out_valid, ev);
    chk("busy", busy, ev);
    chk("overrun", overrun, m_ovr);
    chk("frame_cnt", frame_cnt, m_fcnt);
    if (ev) begin
      chk("ch", bus.out_ch, q[0].ch);
      chk("data", bus.out_data, q[0].d);
      chk("sof", bus.out_sof, q[0].sof);
      chk("eof", bus.out_eof, q.size() == 1);
    end
    lst = ev && q.size() == 1;
    cap = s && ch_mask != 0 && (!ev || (r && lst));
    m_ovr = (s && ch_mask != 0 && ev && !(r && lst)) || (m_ovr && !c);
    if (ev && r) void'(q.pop_front());
    m_gap = 1'b0;
    if (cap) begin
      m_gap = ev;
      q.delete();
      for (int k = 0; k < NUM_CH; k++)
        if (ch_mask[k]) q.push_back('{k, ch_data[k*DATA_W +: DATA_W], q.size() == 0});
      m_fcnt++;
    end
    @(negedge clock);
  endtask
  task automatic do_reset();
    sample_strobe = 1'b0;
    overrun_clr = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_ch", bus.out_ch, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_sof", bus.out_sof, 0);
    chk("rst_eof", bus.out_eof, 0);
    q.delete();
    m_gap = 1'b0;
    m_ovr = 1'b0;
    m_fcnt = '0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask
  initial begin
    bus.out_ready = 1'b0;
    @(negedge clock);
    do_reset();
    fill(1);
    step(1, 1, 0);
    repeat (17) step(0, 1, 0);
    chk("one_frame_cnt", frame_cnt, 1);
    fill(0);
    step(1, 1, 0);
    for (int i = 0; i < 40; i++) step(0, i[0], 0);
    fill(0);
    step(1, 1, 0);
    repeat (4) step(0, 1, 0);
    fill(0);
    step(1, 1, 0);
    repeat (12) step(0, 1, 0);
    step(0, 1, 1);
    step(0, 1, 0);
    fill(0);
    step(1, 1, 0);
    step(1, 1, 1);
    repeat (16) step(0, 1, 0);
    step(0, 0, 1);
    fill(0);
    step(1, 1, 0);
    repeat (15) step(0, 1, 0);
    fill(0);
    step(1, 1, 0);
    repeat (18) step(0, 1, 0);
`ifdef FB_SCHED_CH_MASK_EN
    ch_mask = NUM_CH'(16'h8001);
    fill(0);
    step(1, 1, 0);
    repeat (4) step(0, 1, 0);
    ch_mask = '0;
    step(1, 1, 0);
    repeat (3) step(0, 1, 0);
    ch_mask = '1;
`endif
    fill(0);
    step(1, 1, 0);
    repeat (8) step(0, 1, 0);
    do_reset();
    repeat (5) step(0, 1, 0);
    repeat (3000) begin
      logic s;
      s = ($urandom_range(19) == 0) || (bus.out_eof && $urandom_range(1) == 0);
      fill(0);
`ifdef FB_SCHED_CH_MASK_EN
      ch_mask = ($urandom_range(7) == 0) ? '0 : NUM_CH'($urandom());
`endif
      step(s, $urandom_range(3) != 0, $urandom_range(15) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/fb_out_scheduler.md
FB_OUT_SCHEDULER -- requirements
Module: fb_out_scheduler

Interface
REQ-001 The block SHALL have the parameters NUM_CH (default 16, channel count) and DATA_W (default 39, per-channel sample width); CH_W = clog2(NUM_CH) SHALL be derived.
REQ-002 The port list SHALL be: clock  in  1  single clock; all state on its rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 sample_strobe  in  1  one-cycle pulse: all NUM_CH filter outputs are valid this cycle.
REQ-005 ch_data  in  NUM_CH*DATA_W  flattened signed channel outputs; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-006 ch_mask  in  NUM_CH  channel enable mask; present only with FB_SCHED_CH_MASK_EN.
REQ-007 out_valid / out_ready  out / in  1  stream handshake; a transfer occurs when both are 1.
REQ-008 out_data  out  DATA_W  sample for the current channel.
REQ-009 out_ch  out  CH_W  current channel index.
REQ-010 out_sof / out_eof  out  1  first and last transfer of a frame.
REQ-011 busy  out  1  the block is in STREAM.
REQ-012 overrun  out  1  sticky flag: a sample was dropped.
REQ-013 overrun_clr  in  1  clears overrun.
REQ-014 frame_cnt  out  16  count of frames started, modulo 2^16.

Function
REQ-015 The FSM SHALL have two states, IDLE and STREAM.
REQ-016 In IDLE, sample_strobe SHALL capture ch_data into a NUM_CH x DATA_W snapshot buffer and move to STREAM; out_valid SHALL rise on the following cycle.
REQ-017 In STREAM, out_data and out_ch SHALL present the lowest-index enabled channel not yet sent, and out_sof SHALL be 1 only on the first such channel.
REQ-018 out_data, out_ch, out_sof and out_eof SHALL stay stable while out_valid=1 and out_ready=0.
REQ-019 A transfer SHALL advance to the next enabled channel; a transfer with out_eof=1 SHALL return the FSM to IDLE.
REQ-020 sample_strobe in the same cycle as the out_eof transfer SHALL capture the new snapshot and re-enter STREAM at the first channel; it SHALL NOT set overrun, and out_valid SHALL drop for exactly one cycle.
REQ-021 sample_strobe in STREAM at any other time SHALL set overrun, discard the new data and leave the current frame intact.
REQ-022 frame_cnt SHALL increment on every snapshot capture, wrapping from 0xFFFF to 0.
REQ-023 overrun_clr SHALL clear overrun; if a set and a clear occur in the same cycle, the set SHALL win.
REQ-024 Minimum frame duration with out_ready held at 1 SHALL be NUM_CH transfer cycles plus one capture cycle.

Reset
REQ-025 With reset_n=0 the block SHALL enter IDLE, and out_valid, out_sof, out_eof, busy and overrun SHALL be 0, out_ch SHALL be 0, frame_cnt SHALL be 0 and out_data SHALL be 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately, with no further transfers after deassertion until the next sample_strobe.
REQ-027 The snapshot buffer SHALL be cleared by reset.

Configuration
REQ-028 The macro FB_SCHED_CH_MASK_EN SHALL select channel masking.
REQ-029 With FB_SCHED_CH_MASK_EN defined, ch_mask SHALL be sampled at capture and held for the frame; disabled channels SHALL be skipped.
REQ-030 With FB_SCHED_CH_MASK_EN defined and an all-zero mask at capture, the strobe SHALL be ignored: no frame is started, frame_cnt does not change and overrun does not change.
REQ-031 Without FB_SCHED_CH_MASK_EN, the ch_mask port SHALL be absent and all channels SHALL be emitted in order 0..NUM_CH-1.

Structure
REQ-032 Package fb_pkg SHALL hold NUM_CH, DATA_W, CH_W and the state enumeration, and SHALL be shared with the filter-bank top.
REQ-033 Sub-module fb_next_ch SHALL be a combinational priority encoder that returns the next enabled index at or above the current position, plus a "none left" flag used to generate out_eof.

Verification
REQ-034 Strobe with ch k = k+1 and out_ready=1: 16 transfers, out_ch 0..15, data 1..16, out_sof on ch 0, out_eof on ch 15, frame_cnt=1.
REQ-035 Toggle out_ready 1/0 each cycle during a frame: outputs stay stable during stalls, 16 transfers, no duplicates and no losses.
REQ-036 Second strobe at transfer 5: overrun=1, remaining data taken from the first snapshot, frame_cnt=1; overrun_clr then returns overrun to 0.
REQ-037 Second strobe coincident with the out_eof transfer: overrun=0, new frame starts with out_sof, frame_cnt=2.
REQ-038 With masking enabled and ch_mask=16'h8001: two transfers (ch 0 with sof, ch 15 with eof); ch_mask=0 gives no transfers and frame_cnt unchanged.
REQ-039 reset_n=0 at transfer 8 of a frame: all outputs are at reset values, and no further transfers occur until a new strobe.
